drum_voice_mixer: RTL



---
 rtl/drum_pkg.sv | 20 ++
 rtl/drum_voice.sv | 51 +++++
 rtl/drum_voice_mixer.sv | 108 ++++++++++
 3 files changed

// File: rtl/drum_pkg.sv
// drum_pkg: shared types and constants for the drum mixer
// Optional per-voice gain is enabled by DRUM_MIX_GAIN_EN
package drum_pkg;

  localparam int DEF_SAMPLE_W = 8;
  localparam logic [DEF_SAMPLE_W-1:0] SILENCE =
    DEF_SAMPLE_W'(1 << (DEF_SAMPLE_W - 1));

  typedef enum logic {
    VOICE_IDLE = 1'b0,
    VOICE_PLAY = 1'b1
  } voice_state_t;

  localparam int CYMBAL = 0;
  localparam int HIHAT  = 1;
  localparam int TOM    = 2;
  localparam int SNARE  = 3;
  localparam int KICK   = 4;

endpackage

// File: rtl/drum_voice.sv
// drum_voice: one playback voice, IDLE/PLAY FSM plus ROM address
// Trigger restarts the sample and wins over tick and end-of-sample
module drum_voice
  import drum_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_tick,
  input  logic              trig,
  input  logic [ADDR_W-1:0] last,
  output logic [ADDR_W-1:0] addr,
  output logic              active
);

  voice_state_t      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // State and address registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= VOICE_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next state: trigger, then end-of-sample, then advance, else hold
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if (trig) begin
      state_d = VOICE_PLAY;
      addr_d  = '0;
    end else if (state_q == VOICE_PLAY && sample_tick) begin
      if (addr_q == last) begin
        state_d = VOICE_IDLE;
        addr_d  = '0;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  assign addr   = addr_q;
  assign active = (state_q == VOICE_PLAY);

endmodule

// File: rtl/drum_voice_mixer.sv
// drum_voice_mixer: NUM_VOICES polyphonic sample voices, saturating mix
// Optional per-voice shift gain is enabled by DRUM_MIX_GAIN_EN
module drum_voice_mixer
  import drum_pkg::*;
#(
  parameter int NUM_VOICES = 5,
  parameter int SAMPLE_W   = 8,
  parameter int ADDR_W     = 12
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sample_tick,
  input  logic [NUM_VOICES-1:0]          trig,
  input  logic [NUM_VOICES*ADDR_W-1:0]   voice_last,
  output logic [NUM_VOICES*ADDR_W-1:0]   rom_addr,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] rom_data,
  output logic [NUM_VOICES-1:0]          active,
  output logic [SAMPLE_W-1:0]            mix_out,
  output logic                           clip
`ifdef DRUM_MIX_GAIN_EN
  ,
  input  logic [NUM_VOICES*2-1:0]        voice_gain
`endif
);

  localparam int SUM_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int MAXV  = (2 ** (SAMPLE_W - 1)) - 1;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAXV);
  localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(-MAXV - 1);
  localparam logic [SAMPLE_W-1:0] MID =
    {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [NUM_VOICES-1:0]   active_d1;
  logic [NUM_VOICES*2-1:0] gain_d1;

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    drum_voice #(
      .ADDR_W(ADDR_W)
    ) u_voice (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_tick(sample_tick),
      .trig       (trig[v]),
      .last       (voice_last[v*ADDR_W +: ADDR_W]),
      .addr       (rom_addr[v*ADDR_W +: ADDR_W]),
      .active     (active[v])
    );
  end

  // Delay active flags to line up with registered ROM data
  always_ff @(posedge clk) begin
    if (!rst_n) active_d1 <= '0;
    else        active_d1 <= active;
  end

`ifdef DRUM_MIX_GAIN_EN
  // Gain sampled alongside active_d1 so latency is unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) gain_d1 <= '0;
    else        gain_d1 <= voice_gain;
  end
`else
  assign gain_d1 = '0;
`endif

  logic signed [SAMPLE_W-1:0] contrib;
  logic signed [SUM_W-1:0]    sum;
  logic [SAMPLE_W-1:0]        clamped;
  logic                       sat;
  logic [SAMPLE_W-1:0]        mix_d;

  // Signed contributions, wide sum, clamp, back to offset-binary
  always_comb begin
    contrib = '0;
    sum     = '0;
    clamped = '0;
    sat     = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      contrib = {~rom_data[i*SAMPLE_W + SAMPLE_W - 1],
                 rom_data[i*SAMPLE_W +: SAMPLE_W-1]};
      contrib = contrib >>> gain_d1[2*i +: 2];
      if (!active_d1[i]) contrib = '0;
      sum = sum + SUM_W'(contrib);
    end
    if (sum > MAX_S) begin
      clamped = MAX_S[SAMPLE_W-1:0];
      sat     = 1'b1;
    end else if (sum < MIN_S) begin
      clamped = MIN_S[SAMPLE_W-1:0];
      sat     = 1'b1;
    end else begin
      clamped = sum[SAMPLE_W-1:0];
    end
    mix_d = {~clamped[SAMPLE_W-1], clamped[SAMPLE_W-2:0]};
  end

  // Output register to the DAC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mix_out <= MID;
      clip    <= 1'b0;
    end else begin
      mix_out <= mix_d;
      clip    <= sat;
    end
  end

endmodule
